// File: rtl/serial_stim_source.sv
// Parallel-to-serial stimulus source that feeds the sequence FSM's x_in.
// It captures a word on a load/ready handshake and then emits one bit per clock, with a hold input that stalls it.
module serial_stim_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg;

  // Bit that leaves the word next, in the chosen serialization order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign state = state_r;
  assign ready = (state_r == IDLE);
  assign busy  = (state_r != IDLE);

  // shreg always holds the bits still to be sent, so that the next one sits at the head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      shreg   <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          done    <= 1'b0;
          if (load) begin
            shreg   <= shift_word(din);
            x_out   <= head_bit(din);
            x_valid <= 1'b1;
            bit_cnt <= '0;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (bit_cnt == LAST_IDX) begin
              x_out   <= 1'b0;
              x_valid <= 1'b0;
              done    <= 1'b1;
              bit_cnt <= '0;
              state_r <= DONE;
            end else begin
              x_out   <= head_bit(shreg);
              shreg   <= shift_word(shreg);
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          // Recovery from the unused code 2'b11: the outputs are set as at reset.
          state_r <= IDLE;
          shreg   <= '0;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          done    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
